// File: rtl/cfg_pkg.sv
// Shared constants and types for the Si5340 I2C responder and its line synchroniser.
package cfg_pkg;

  localparam logic [6:0]            SLAVE_ADDR  = 7'b111_0100;
  localparam int                    DATA_WIDTH  = 8;
  localparam logic [DATA_WIDTH-1:0] PAGE_REG    = 8'h01;
  localparam int                    SYNC_STAGES = 2;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } r_w_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } resp_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk_i domain and derives SCL edges plus START/STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = cfg_pkg::SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] r_sclSync;
  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic                   r_sclPrev;
  logic                   r_sdaPrev;
  logic                   w_scl;
  logic                   w_sda;

  // Everything resets to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl_i};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda_i};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

  assign w_scl      = r_sclSync[SYNC_STAGES-1];
  assign w_sda      = r_sdaSync[SYNC_STAGES-1];
  assign sda_o      = w_sda;
  assign scl_rise_o = w_scl & ~r_sclPrev;
  assign scl_fall_o = ~w_scl & r_sclPrev;
  // SCL must be high on both samples, so a simultaneous SCL/SDA drop is not a START.
  assign start_o    = r_sdaPrev & ~w_sda & w_scl & r_sclPrev;
  assign stop_o     = ~r_sdaPrev & w_sda & w_scl & r_sclPrev;

endmodule

// File: rtl/si5340_i2c_responder.sv
// Si5340-style I2C target: turns page/register writes into {page,reg}+data strobes.
// Read path is built only when CFG_RESP_READ_EN is defined.
module si5340_i2c_responder
  import cfg_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    wr_vld_o,
  output logic [2*DATA_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic                    rd_req_o,
  output logic [2*DATA_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i
);

`ifdef CFG_RESP_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  localparam logic [3:0] LAST_BIT  = 4'd7;
  localparam logic [3:0] BYTE_DONE = 4'd8;

  resp_state_t                 r_state;
  logic [3:0]                  r_bitCnt;
  logic [DATA_WIDTH-1:0]       r_shift;
  logic [DATA_WIDTH-1:0]       r_page;
  logic [DATA_WIDTH-1:0]       r_ptr;
  logic                        r_firstByte;
  logic                        r_isRead;
  logic                        r_ackSeen;
  logic                        r_rdCap;
  logic                        r_sdaOe;
  logic                        r_busy;
  logic                        r_frameDone;
  logic                        r_wrVld;
  logic [2*DATA_WIDTH-1:0]     r_wrAddr;
  logic [DATA_WIDTH-1:0]       r_wrData;
  logic                        r_rdReq;
  logic [2*DATA_WIDTH-1:0]     r_rdAddr;

  logic                        w_sda;
  logic                        w_sclRise;
  logic                        w_sclFall;
  logic                        w_start;
  logic                        w_stop;
  logic [DATA_WIDTH-1:0]       w_byteIn;
  logic                        w_addrHit;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (w_sda),
    .scl_rise_o (w_sclRise),
    .scl_fall_o (w_sclFall),
    .start_o    (w_start),
    .stop_o     (w_stop)
  );

  assign w_byteIn  = {r_shift[DATA_WIDTH-2:0], w_sda};
  assign w_addrHit = (w_byteIn[DATA_WIDTH-1:1] == SLAVE_ADDR) &&
                     ((w_byteIn[0] == RW_WRITE) || READ_EN);

  // START/STOP win over bit activity; each byte completes on its 8th SCL rise, ACK spans fall-to-fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_page      <= '0;
      r_ptr       <= '0;
      r_firstByte <= 1'b0;
      r_isRead    <= 1'b0;
      r_ackSeen   <= 1'b0;
      r_rdCap     <= 1'b0;
      r_sdaOe     <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_wrVld     <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_rdReq     <= 1'b0;
      r_rdAddr    <= '0;
    end else begin
      r_frameDone <= 1'b0;
      r_wrVld     <= 1'b0;
      r_rdReq     <= 1'b0;
      r_rdCap     <= r_rdReq;
      if (w_stop) begin
        r_state     <= IDLE;
        r_sdaOe     <= 1'b0;
        r_busy      <= 1'b0;
        r_frameDone <= 1'b1;
        r_bitCnt    <= '0;
      end else if (w_start) begin
        r_state     <= ADDR;
        r_sdaOe     <= 1'b0;
        r_busy      <= 1'b1;
        r_bitCnt    <= '0;
        r_firstByte <= 1'b1;
      end else begin
        unique case (r_state)
          ADDR: begin
            if (w_sclRise && r_bitCnt != BYTE_DONE) begin
              r_shift  <= w_byteIn;
              r_bitCnt <= r_bitCnt + 4'd1;
              if (r_bitCnt == LAST_BIT) begin
                r_isRead <= w_byteIn[0];
                if (!w_addrHit) r_state <= IGNORE;
              end
            end else if (w_sclFall && r_bitCnt == BYTE_DONE) begin
              r_sdaOe <= 1'b1;
              r_state <= ADDR_ACK;
              if (r_isRead) begin
                r_rdReq  <= 1'b1;
                r_rdAddr <= {r_page, r_ptr};
              end
            end
          end
          ADDR_ACK: begin
            if (w_sclFall) begin
              r_bitCnt <= '0;
              if (r_isRead) begin
                r_sdaOe <= ~r_shift[DATA_WIDTH-1];
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                r_state <= RD_BYTE;
              end else begin
                r_sdaOe <= 1'b0;
                r_state <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (w_sclRise && r_bitCnt != BYTE_DONE) begin
              r_shift  <= w_byteIn;
              r_bitCnt <= r_bitCnt + 4'd1;
              if (r_bitCnt == LAST_BIT) begin
                if (r_firstByte) begin
                  r_ptr       <= w_byteIn;
                  r_firstByte <= 1'b0;
                end else begin
                  r_wrVld  <= 1'b1;
                  r_wrAddr <= {r_page, r_ptr};
                  r_wrData <= w_byteIn;
                  if (r_ptr == PAGE_REG) r_page <= w_byteIn;
                  r_ptr    <= r_ptr + 8'd1;
                end
              end
            end else if (w_sclFall && r_bitCnt == BYTE_DONE) begin
              r_sdaOe <= 1'b1;
              r_state <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (w_sclFall) begin
              r_sdaOe  <= 1'b0;
              r_bitCnt <= '0;
              r_state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (w_sclRise && r_bitCnt != BYTE_DONE) begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end else if (w_sclFall) begin
              if (r_bitCnt == BYTE_DONE) begin
                r_sdaOe   <= 1'b0;
                r_ackSeen <= 1'b0;
                r_state   <= RD_ACK;
              end else begin
                r_sdaOe <= ~r_shift[DATA_WIDTH-1];
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (w_sclRise && !r_ackSeen) begin
              if (w_sda) begin
                r_state <= IGNORE;
              end else begin
                r_ackSeen <= 1'b1;
                r_ptr     <= r_ptr + 8'd1;
                r_rdReq   <= 1'b1;
                r_rdAddr  <= {r_page, r_ptr + 8'd1};
              end
            end else if (w_sclFall && r_ackSeen) begin
              r_bitCnt <= '0;
              r_sdaOe  <= ~r_shift[DATA_WIDTH-1];
              r_shift  <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_state  <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
      if (r_rdCap) r_shift <= rd_data_i;
    end
  end

  assign sda_oe_o     = r_sdaOe;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frameDone;
  assign wr_vld_o     = r_wrVld;
  assign wr_addr_o    = r_wrAddr;
  assign wr_data_o    = r_wrData;

`ifdef CFG_RESP_READ_EN
  assign rd_req_o  = r_rdReq;
  assign rd_addr_o = r_rdAddr;
`else
  logic w_unusedRd;
  assign w_unusedRd = r_rdReq ^ (^r_rdAddr);
  assign rd_req_o   = 1'b0;
  assign rd_addr_o  = '0;
`endif

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// Directed plus randomized bench for si5340_i2c_responder, scored against a frame-level register model.
module tb_si5340_i2c_responder;

  localparam int Q = 5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        scl_i;
  logic        sda_i;
  logic        r_sdaM;
  logic        sda_oe_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        wr_vld_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        rd_req_o;
  logic [15:0] rd_addr_o;
  logic [7:0]  rd_data_i = 8'h00;

  int          assertCount = 0;
  int          failCount   = 0;
  int          frameDoneCnt = 0;
  int          expFrameDone = 0;
  int          oeCycles = 0;

  logic [15:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];
  logic [15:0] rdAddrQ[$];
  logic [15:0] expAddrQ[$];
  logic [7:0]  expDataQ[$];
  logic [15:0] expRdQ[$];
  logic [7:0]  frameBytes[$];
  logic [7:0]  mPage;
  logic [7:0]  mPtr;

  always #5 clk_i = ~clk_i;

  // Open-drain bus: the master's level wired-AND with the responder's pull-down.
  assign sda_i = r_sdaM & ~sda_oe_o;

  si5340_i2c_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .sda_oe_o     (sda_oe_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .wr_vld_o     (wr_vld_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .rd_req_o     (rd_req_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i)
  );

  function automatic logic [7:0] memVal(input logic [15:0] a);
    return a[7:0] + 8'h3A;
  endfunction

  // Register-file stand-in and output monitors, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (wr_vld_o) begin
      wrAddrQ.push_back(wr_addr_o);
      wrDataQ.push_back(wr_data_o);
    end
    if (frame_done_o) frameDoneCnt++;
    if (sda_oe_o) oeCycles++;
    if (rd_req_o) begin
      rdAddrQ.push_back(rd_addr_o);
      rd_data_i = memVal(rd_addr_o);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clockBit(input logic drive, output logic seen);
    r_sdaM = drive;
    waitClk(Q);
    scl_i = 1'b1;
    waitClk(Q);
    seen = sda_i;
    waitClk(Q);
    scl_i = 1'b0;
    waitClk(Q);
  endtask

  task automatic startCond();
    r_sdaM = 1'b1;
    waitClk(Q);
    scl_i = 1'b1;
    waitClk(2*Q);
    r_sdaM = 1'b0;
    waitClk(2*Q);
    scl_i = 1'b0;
    waitClk(Q);
  endtask

  task automatic stopCond();
    r_sdaM = 1'b0;
    waitClk(Q);
    scl_i = 1'b1;
    waitClk(2*Q);
    r_sdaM = 1'b1;
    waitClk(2*Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ackBit);
    logic unusedSeen;
    for (int i = 7; i >= 0; i--) clockBit(b[i], unusedSeen);
    clockBit(1'b1, ackBit);
  endtask

  task automatic recvByte(input logic masterNack, output logic [7:0] b);
    logic unusedSeen;
    for (int i = 7; i >= 0; i--) clockBit(1'b1, b[i]);
    clockBit(masterNack, unusedSeen);
  endtask

  task automatic checkStrobes(input string tag);
    checkOutput({tag, " strobe count"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
    while (wrAddrQ.size() > 0 && expAddrQ.size() > 0) begin
      checkOutput({tag, " wr_addr"}, 32'(wrAddrQ.pop_front()), 32'(expAddrQ.pop_front()));
      checkOutput({tag, " wr_data"}, 32'(wrDataQ.pop_front()), 32'(expDataQ.pop_front()));
    end
    wrAddrQ.delete();
    wrDataQ.delete();
    expAddrQ.delete();
    expDataQ.delete();
    checkOutput({tag, " frame_done count"}, 32'(frameDoneCnt), 32'(expFrameDone));
  endtask

  // One complete frame: address byte then frameBytes, then STOP; the model predicts ACKs and strobes.
  task automatic applyStimulus(input string tag, input logic [7:0] addrByte);
    logic ackBit;
    logic hit;
    hit = (addrByte == 8'hE8);
    startCond();
    sendByte(addrByte, ackBit);
    checkOutput({tag, " addr ack"}, 32'(ackBit), hit ? 32'd0 : 32'd1);
    for (int i = 0; i < frameBytes.size(); i++) begin
      sendByte(frameBytes[i], ackBit);
      checkOutput({tag, " data ack"}, 32'(ackBit), hit ? 32'd0 : 32'd1);
      if (hit) begin
        if (i == 0) begin
          mPtr = frameBytes[i];
        end else begin
          expAddrQ.push_back({mPage, mPtr});
          expDataQ.push_back(frameBytes[i]);
          if (mPtr == 8'h01) mPage = frameBytes[i];
          mPtr = mPtr + 8'd1;
        end
      end
    end
    checkOutput({tag, " busy before stop"}, 32'(busy_o), 32'd1);
    stopCond();
    waitClk(4);
    expFrameDone++;
    checkOutput({tag, " busy after stop"}, 32'(busy_o), 32'd0);
    checkStrobes(tag);
  endtask

  initial begin
    logic       ackBit;
    logic       unusedSeen;
    logic [7:0] rb;
    logic [6:0] a;
    logic [7:0] addrByte;
    int         n;
    int         oeBefore;

    rst_i  = 1'b1;
    scl_i  = 1'b1;
    r_sdaM = 1'b1;
    mPage  = 8'h00;
    mPtr   = 8'h00;
    waitClk(5);
    rst_i = 1'b0;
    waitClk(3);
    $display("[TB] reset state");
    checkOutput("reset sda_oe_o", 32'(sda_oe_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset frame_done_o", 32'(frame_done_o), 32'd0);
    checkOutput("reset wr_vld_o", 32'(wr_vld_o), 32'd0);
    checkOutput("reset wr_addr_o", 32'(wr_addr_o), 32'd0);
    checkOutput("reset wr_data_o", 32'(wr_data_o), 32'd0);
    checkOutput("reset rd_req_o", 32'(rd_req_o), 32'd0);
    checkOutput("reset rd_addr_o", 32'(rd_addr_o), 32'd0);

    $display("[TB] page select then burst write");
    frameBytes = '{8'h01, 8'h02};
    applyStimulus("t1a", 8'hE8);
    frameBytes = '{8'h10, 8'hAB, 8'hCD};
    applyStimulus("t1b", 8'hE8);

    $display("[TB] foreign address");
    oeBefore = oeCycles;
    frameBytes = '{8'h10, 8'hAB};
    applyStimulus("t2", 8'hEA);
    checkOutput("t2 sda_oe cycles", 32'(oeCycles - oeBefore), 32'd0);

    $display("[TB] reset mid-byte");
    startCond();
    sendByte(8'hE8, ackBit);
    checkOutput("t4 addr ack", 32'(ackBit), 32'd0);
    sendByte(8'h30, ackBit);
    checkOutput("t4 ptr ack", 32'(ackBit), 32'd0);
    for (int i = 0; i < 4; i++) clockBit(1'b1, unusedSeen);
    rst_i = 1'b1;
    waitClk(2);
    rst_i = 1'b0;
    mPage = 8'h00;
    mPtr  = 8'h00;
    waitClk(1);
    checkOutput("t4 sda_oe after reset", 32'(sda_oe_o), 32'd0);
    checkOutput("t4 busy after reset", 32'(busy_o), 32'd0);
    stopCond();
    waitClk(4);
    expFrameDone++;
    checkStrobes("t4 aborted");
    frameBytes = '{8'h05, 8'h11};
    applyStimulus("t4 next", 8'hE8);

    $display("[TB] STOP inside a data byte");
    startCond();
    sendByte(8'hE8, ackBit);
    checkOutput("t5 addr ack", 32'(ackBit), 32'd0);
    sendByte(8'h40, ackBit);
    checkOutput("t5 ptr ack", 32'(ackBit), 32'd0);
    mPtr = 8'h40;
    for (int i = 0; i < 3; i++) clockBit(1'b1, unusedSeen);
    stopCond();
    waitClk(4);
    expFrameDone++;
    checkOutput("t5 busy after stop", 32'(busy_o), 32'd0);
    checkStrobes("t5");

`ifdef CFG_RESP_READ_EN
    $display("[TB] register read with repeated start");
    startCond();
    sendByte(8'hE8, ackBit);
    checkOutput("t3 addr ack", 32'(ackBit), 32'd0);
    sendByte(8'h20, ackBit);
    checkOutput("t3 ptr ack", 32'(ackBit), 32'd0);
    mPtr = 8'h20;
    startCond();
    sendByte(8'hE9, ackBit);
    checkOutput("t3 read addr ack", 32'(ackBit), 32'd0);
    expRdQ.push_back({mPage, mPtr});
    recvByte(1'b0, rb);
    checkOutput("t3 read byte 0", 32'(rb), 32'(memVal({mPage, mPtr})));
    mPtr = mPtr + 8'd1;
    expRdQ.push_back({mPage, mPtr});
    recvByte(1'b1, rb);
    checkOutput("t3 read byte 1", 32'(rb), 32'(memVal({mPage, mPtr})));
    waitClk(2);
    checkOutput("t3 sda_oe after nack", 32'(sda_oe_o), 32'd0);
    checkOutput("t3 bus after nack", 32'(sda_i), 32'd1);
    stopCond();
    waitClk(4);
    expFrameDone++;
    checkOutput("t3 rd_req count", 32'(rdAddrQ.size()), 32'(expRdQ.size()));
    while (rdAddrQ.size() > 0 && expRdQ.size() > 0)
      checkOutput("t3 rd_addr", 32'(rdAddrQ.pop_front()), 32'(expRdQ.pop_front()));
    checkStrobes("t3");
`else
    $display("[TB] read request without read path");
    startCond();
    sendByte(8'hE9, ackBit);
    checkOutput("t6 read addr nack", 32'(ackBit), 32'd1);
    stopCond();
    waitClk(4);
    expFrameDone++;
    checkOutput("t6 rd_req count", 32'(rdAddrQ.size()), 32'd0);
    checkStrobes("t6");
`endif

    $display("[TB] randomized write frames");
    for (int f = 0; f < 6; f++) begin
      frameBytes.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        frameBytes.push_back(($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h74) a = 7'h75;
        addrByte = {a, 1'b0};
      end else begin
        addrByte = 8'hE8;
      end
      applyStimulus("rand", addrByte);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
